// File: rtl/ucom_mtimer.sv
// ucom_mtimer: a bank of independent down-counting interval timers.
// Each channel is a PRE_W-bit prescaler feeding a CNT_W-bit down counter,
// with one-shot or auto-reload mode, a sticky timeout flag and a stop control.
// Optional build macro TMR_IRQ_EN: when defined, irq is a registered
// |(tm & ie); when undefined, irq is tied low and ie is ignored.
module ucom_mtimer #(
  parameter int CHANNELS = 2,
  parameter int CH_W     = 1,
  parameter int CNT_W    = 6,
  parameter int PRE_W    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_en,
  input  logic                ld,
  input  logic [CH_W-1:0]     ld_ch,
  input  logic [CNT_W-1:0]    ld_val,
  input  logic                ld_mode,
  input  logic                stop,
  input  logic [CH_W-1:0]     stop_ch,
  input  logic                tm_clr,
  input  logic [CH_W-1:0]     tm_clr_ch,
  input  logic [CHANNELS-1:0] ie,
  output logic [CHANNELS-1:0] tm,
  output logic [CHANNELS-1:0] running,
  output logic                irq
);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    // Channel index as a select-bus value; selects above CHANNELS-1 never match.
    localparam logic [CH_W-1:0] CH_IDX = CH_W'(k);

    logic [PRE_W-1:0] pcount;
    logic [CNT_W-1:0] bcount;
    logic [CNT_W-1:0] reload;
    logic             mode;
    logic             run;
    logic             flag;

    logic sel_ld;
    logic sel_stop;
    logic sel_clr;

    assign sel_ld   = ld && (ld_ch == CH_IDX);
    assign sel_stop = stop && (stop_ch == CH_IDX);
    assign sel_clr  = tm_clr && (tm_clr_ch == CH_IDX);

    // Channel state: load beats stop/clear/timeout, stop beats the tick,
    // and a timeout set beats a same-cycle clear (later assignment wins).
    always_ff @(posedge clk) begin
      if (!reset) begin
        pcount <= '0;
        bcount <= '0;
        reload <= '0;
        mode   <= 1'b0;
        run    <= 1'b0;
        flag   <= 1'b1;
      end else if (sel_ld) begin
        pcount <= '0;
        bcount <= ld_val;
        reload <= ld_val;
        mode   <= ld_mode;
        run    <= 1'b1;
        flag   <= 1'b0;
      end else begin
        if (sel_clr) begin
          flag <= 1'b0;
        end
        if (sel_stop) begin
          run <= 1'b0;
        end else if (clk_en && run) begin
          pcount <= pcount + 1'b1;
          if (&pcount) begin
            if (bcount != '0) begin
              bcount <= bcount - 1'b1;
            end else begin
              flag <= 1'b1;
              if (mode) begin
                bcount <= reload;
              end else begin
                run <= 1'b0;
              end
            end
          end
        end
      end
    end

    assign tm[k]      = flag;
    assign running[k] = run;
  end

`ifdef TMR_IRQ_EN
  // Combined interrupt, registered so it trails the flags by one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |(tm & ie);
    end
  end
`else
  logic unused_ie;
  assign unused_ie = ^ie;
  assign irq       = 1'b0;
`endif

endmodule

// File: tb/tb_ucom_mtimer.sv
// Bench for ucom_mtimer (CHANNELS=2, CNT_W=4, PRE_W=2). A tick-counting
// reference model runs beside the DUT and is compared every cycle; directed
// scenarios also pin exact timing with literal expectations.
module tb_ucom_mtimer;
  localparam int CHANNELS = 2;
  localparam int CH_W     = 1;
  localparam int CNT_W    = 4;
  localparam int PRE_W    = 2;
  localparam int PRE_N    = 1 << PRE_W;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                clk_en = 1'b0;
  logic                ld = 1'b0;
  logic [CH_W-1:0]     ld_ch = '0;
  logic [CNT_W-1:0]    ld_val = '0;
  logic                ld_mode = 1'b0;
  logic                stop = 1'b0;
  logic [CH_W-1:0]     stop_ch = '0;
  logic                tm_clr = 1'b0;
  logic [CH_W-1:0]     tm_clr_ch = '0;
  logic [CHANNELS-1:0] ie = '0;
  logic [CHANNELS-1:0] tm;
  logic [CHANNELS-1:0] running;
  logic                irq;

  int checks = 0;
  int failures = 0;
  bit toggle = 1'b0;
  bit cmp_on = 1'b0;

  ucom_mtimer #(.CHANNELS(CHANNELS), .CH_W(CH_W), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .ld(ld), .ld_ch(ld_ch), .ld_val(ld_val), .ld_mode(ld_mode),
    .stop(stop), .stop_ch(stop_ch), .tm_clr(tm_clr), .tm_clr_ch(tm_clr_ch),
    .ie(ie), .tm(tm), .running(running), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: ticks elapsed in the current period against the period length.
  int                  m_ticks  [CHANNELS];
  int                  m_period [CHANNELS];
  bit                  m_mode   [CHANNELS];
  logic [CHANNELS-1:0] m_tm  = '1;
  logic [CHANNELS-1:0] m_run = '0;
  logic                m_irq = 1'b0;

  always @(posedge clk) begin
`ifdef TMR_IRQ_EN
    m_irq <= reset ? |(m_tm & ie) : 1'b0;
`else
    m_irq <= 1'b0;
`endif
    for (int k = 0; k < CHANNELS; k++) begin
      if (!reset) begin
        m_ticks[k]  <= 0;
        m_period[k] <= PRE_N;
        m_mode[k]   <= 1'b0;
        m_run[k]    <= 1'b0;
        m_tm[k]     <= 1'b1;
      end else if (ld && int'(ld_ch) == k) begin
        m_ticks[k]  <= 0;
        m_period[k] <= (int'(ld_val) + 1) * PRE_N;
        m_mode[k]   <= ld_mode;
        m_run[k]    <= 1'b1;
        m_tm[k]     <= 1'b0;
      end else begin
        if (tm_clr && int'(tm_clr_ch) == k) m_tm[k] <= 1'b0;
        if (stop && int'(stop_ch) == k) begin
          m_run[k] <= 1'b0;
        end else if (clk_en && m_run[k]) begin
          if (m_ticks[k] + 1 == m_period[k]) begin
            m_tm[k]    <= 1'b1;
            m_ticks[k] <= 0;
            if (!m_mode[k]) m_run[k] <= 1'b0;
          end else begin
            m_ticks[k] <= m_ticks[k] + 1;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (cmp_on) begin
      checks++;
      if (tm !== m_tm || running !== m_run || irq !== m_irq) begin
        failures++;
        $display("FAIL model_cmp t=%0t tm=%b/%b running=%b/%b irq=%b/%b (actual/required)",
                 $time, tm, m_tm, running, m_run, irq, m_irq);
      end
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic step();
    if (toggle) clk_en = !clk_en;
    @(negedge clk);
  endtask

  task automatic load(input int ch, input int val, input bit mode);
    ld = 1'b1; ld_ch = CH_W'(ch); ld_val = CNT_W'(val); ld_mode = mode;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic wait_tm(input int ch, input int max, output int n, output int ticks);
    n = 0; ticks = 0;
    while (!tm[ch] && n < max) begin
      if (toggle) clk_en = !clk_en;
      if (clk_en) ticks++;
      @(negedge clk);
      n++;
    end
  endtask

  int n, t;
  int exp_irq;

  initial begin
    repeat (3) @(negedge clk);
    cmp_on = 1'b1;
    reset = 1'b1;
    check("reset_tm", int'(tm), 3);
    check("reset_running", int'(running), 0);
    check("reset_irq", int'(irq), 0);

    // One-shot, ld_val=3: 16 ticks to timeout.
    clk_en = 1'b1;
    load(0, 3, 1'b0);
    wait_tm(0, 40, n, t);
    check("oneshot_cycles", n, 16);
    check("oneshot_running_fall", int'(running[0]), 0);
    repeat (20) step();
    check("oneshot_tm_sticky", int'(tm[0]), 1);

    // Auto-reload, ld_val=1, clk_en toggling.
    toggle = 1'b1;
    load(1, 1, 1'b1);
    wait_tm(1, 40, n, t);
    check("autorl_cycles", n, 16);
    check("autorl_ticks", t, 8);
    tm_clr = 1'b1; tm_clr_ch = 1'b1;
    step();
    tm_clr = 1'b0;
    check("autorl_cleared", int'(tm[1]), 0);
    wait_tm(1, 40, n, t);
    check("autorl_ticks2", t, 8);
    check("autorl_running", int'(running[1]), 1);
    toggle = 1'b0;
    clk_en = 1'b1;

    // ld + tm_clr in the timeout cycle: load wins.
    load(0, 0, 1'b0);
    repeat (3) step();
    ld = 1'b1; ld_ch = 1'b0; ld_val = 4'd2; ld_mode = 1'b0;
    tm_clr = 1'b1; tm_clr_ch = 1'b0;
    step();
    ld = 1'b0; tm_clr = 1'b0;
    check("ld_wins_tm", int'(tm[0]), 0);
    check("ld_wins_running", int'(running[0]), 1);
    wait_tm(0, 40, n, t);
    check("ld_wins_reload_cycles", n, 12);

    // tm_clr in the timeout cycle: set wins.
    load(0, 0, 1'b0);
    repeat (3) step();
    tm_clr = 1'b1; tm_clr_ch = 1'b0;
    step();
    tm_clr = 1'b0;
    check("set_wins_tm", int'(tm[0]), 1);
    check("set_wins_running", int'(running[0]), 0);

    // Stop mid-count (bcount=2), idle 50 ticks, then a fresh load.
    load(0, 3, 1'b0);
    repeat (6) step();
    stop = 1'b1; stop_ch = 1'b0;
    step();
    stop = 1'b0;
    repeat (50) step();
    check("stop_tm", int'(tm[0]), 0);
    check("stop_running", int'(running[0]), 0);
    load(0, 3, 1'b0);
    wait_tm(0, 40, n, t);
    check("stop_reload_cycles", n, 16);

    // Interrupt path: ch0 expired but masked, ch1 enabled.
    ie = 2'b10;
    load(1, 1, 1'b1);
    step();
    check("irq_ch0_masked", int'(irq), 0);
    wait_tm(1, 40, n, t);
    check("irq_tm1_cycles", n, 7);
    check("irq_lag", int'(irq), 0);
    step();
`ifdef TMR_IRQ_EN
    exp_irq = 1;
`else
    exp_irq = 0;
`endif
    check("irq_assert", int'(irq), exp_irq);
    tm_clr = 1'b1; tm_clr_ch = 1'b1;
    step();
    tm_clr = 1'b0;
    check("irq_hold_after_clr", int'(irq), exp_irq);
    step();
    check("irq_drop", int'(irq), 0);

    repeat (5) step();
    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
